nios2_system_v0_button_pio: RTL
===============================

# nios2_system_v0_button_pio

Memory-mapped input PIO for the pushbutton/switch bank: synchronises and debounces `in_port`, latches selected edges into a sticky edge-capture register and raises a level interrupt to the Nios II. It sits on the Avalon-MM data master as a zero-wait-state slave. It is the input-side counterpart to the LED output PIO and uses the same 2-bit register address space.

## Interface
Parameters:
- `WIDTH`, 4: number of input bits, 1..32.
- `EDGE_TYPE`, 1: edge captured; 0 = rising, 1 = falling, 2 = any.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required before a level change is accepted, ≥ 2. Used only with `BUTTON_PIO_DEBOUNCE_EN`.

Ports:
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `address` input 2: register select.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe.
- `writedata` input 32: write data.
- `in_port` input WIDTH: asynchronous button inputs, active-low, idle high.
- `readdata` output 32: read data, combinational, zero read latency.
- `irq` output 1: level interrupt, active-high.

## Operation
- Input path: `in_port` → 2-FF synchroniser (`sync1`, `sync2`) → per-bit debouncer (when enabled) → `db` (accepted level) → `db_prev` → edge detect.
- Register map, with unused readdata bits reading 0:
  - 0, data (RO): `db`.
  - 1: reads 0; writes are ignored.
  - 2, irqmask (RW): bit i enables irq for bit i.
  - 3, edgecapture (R/W1C): sticky captured edges. Writing 1 to bit i clears that bit; writing 0 leaves it unchanged.
- A write occurs when `chipselect && !write_n` in a cycle; it decodes on `address` and takes effect at that clock edge. Reads have no side effects.
- Edge detect per bit:
  - rise = `db & ~db_prev`
  - fall = `~db & db_prev`
  - any = rise | fall
- Each cycle, a detected edge sets `edgecapture[i]`. When a set and a W1C clear hit the same bit in the same cycle, the set wins.
- `irq` = |(`edgecapture` & `irqmask`), registered from the current register values with no extra pipeline stage.
- Debouncer, one counter per bit, width clog2(DEBOUNCE_CYCLES):
  - If `sync2[i] == db[i]`, the counter is cleared to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and the bit still differs, then at that edge `db[i] <= sync2[i]` and the counter returns to 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes `db`.
- Reset values:
  - `sync1`, `sync2`, `db`, `db_prev`: all ones (matches idle released buttons, so no spurious edge after reset).
  - Counters, `irqmask`, `edgecapture`: 0.
  - `irq`: 0.
  - `readdata`: follows `address` from these reset values.
- Reset asserted mid-debounce discards the partial count and any pending edges.

## Timing
- A change on `in_port` is sampled into `sync2` after the 2nd rising edge.
- Without debounce, `db` = `sync2`, so data reads reflect the change after edge 2. `edgecapture` and `irq` assert after edge 3.
- With debounce, `db` updates after edge 2+DEBOUNCE_CYCLES, and `edgecapture`/`irq` assert after edge 3+DEBOUNCE_CYCLES.
- A W1C write at edge N clears `edgecapture` bits, and `irq` deasserts in the cycle after edge N, unless an edge sets the bit again at edge N.
- An irqmask write at edge N affects `irq` from the cycle after edge N.
- `readdata` is valid in the same cycle as `address` (combinational mux).

## Configuration
- `BUTTON_PIO_DEBOUNCE_EN` defined:
  - The per-bit debounce counters are instantiated.
  - `DEBOUNCE_CYCLES` applies.
- Not defined:
  - No counters are built.
  - `db` is `sync2` directly (register alias), giving a 2-cycle input-to-data latency.
  - `DEBOUNCE_CYCLES` is ignored.

## Test plan
- **Reset.** Assert `reset` for 2 cycles with `in_port`=4'hF, then release.
  - Address 0 reads 0x0000000F.
  - Addresses 2 and 3 read 0.
  - `irq`=0 for 10 cycles.
- **Falling edge capture, debounce off.** Write 4'h1 to irqmask, then drive `in_port`=4'hE.
  - Address 0 reads 0xE after edge 2.
  - `edgecapture`=0x1 and `irq`=1 after edge 3.
  - Writing 0x1 to address 3 drops `irq` the next cycle.
- **Masking.** With irqmask=0, drive bit 2 low.
  - `edgecapture`=0x4 and `irq`=0.
  - A later write of 0x4 to irqmask raises `irq` the next cycle.
- **Set/clear collision.** Write 0x1 to address 3 in the exact cycle a new falling edge on bit 0 is detected.
  - `edgecapture[0]` stays 1 and `irq` stays 1.
- **Debounce, `BUTTON_PIO_DEBOUNCE_EN`, `DEBOUNCE_CYCLES`=8.**
  - A 5-cycle low pulse on bit 1 leaves data=0xF and `edgecapture`=0.
  - A sustained low on bit 1 gives data=0xD after edge 10 and `edgecapture`=0x2 after edge 11.
- **Reset mid-debounce.** With `DEBOUNCE_CYCLES`=8, hold bit 0 low for 5 cycles, then pulse `reset`.
  - The counter restarts from 0.
  - data=0xE appears only after 2+8 edges following reset release.

Source files
------------

// File: rtl/nios2_system_v0_button_pio.sv
// Avalon-MM input PIO: synchronised, optionally debounced buttons with sticky edge capture and irq.
// Define BUTTON_PIO_DEBOUNCE_EN to build the per-bit debounce counters.
module nios2_system_v0_button_pio #(
   parameter int WIDTH           = 4,
   parameter int EDGE_TYPE       = 1,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] db;
   logic [WIDTH-1:0] db_prev;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecapture;
   logic [WIDTH-1:0] edges;
   logic [WIDTH-1:0] ec_next;
   logic [WIDTH-1:0] mask_next;
   logic             wr_en;
   logic             unused_wd;

   assign wr_en     = chipselect && !write_n;
   assign unused_wd = ^writedata;

   // Synchroniser resets to the released (high) level so reset exit never looks like a press.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
      end
   end

`ifdef BUTTON_PIO_DEBOUNCE_EN
   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt [WIDTH];

   // A level is accepted only after it has differed from db for DEBOUNCE_CYCLES samples in a row.
   always_ff @(posedge clk) begin
      if (reset) begin
         db <= '1;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               db[i]  <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end
`else
   assign db = sync2;
`endif

   always_comb begin
      case (EDGE_TYPE)
         0:       edges = db & ~db_prev;
         2:       edges = db ^ db_prev;
         default: edges = ~db & db_prev;
      endcase
   end

   // Set beats W1C clear when both hit the same bit in one cycle.
   always_comb begin
      ec_next   = edgecapture;
      mask_next = irqmask;
      if (wr_en && address == 2'd3) ec_next = edgecapture & ~writedata[WIDTH-1:0];
      if (wr_en && address == 2'd2) mask_next = writedata[WIDTH-1:0];
      ec_next = ec_next | edges;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         db_prev     <= '1;
         irqmask     <= '0;
         edgecapture <= '0;
         irq         <= 1'b0;
      end else begin
         db_prev     <= db;
         irqmask     <= mask_next;
         edgecapture <= ec_next;
         irq         <= |(ec_next & mask_next);
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata[WIDTH-1:0] = db;
         2'd2:    readdata[WIDTH-1:0] = irqmask;
         2'd3:    readdata[WIDTH-1:0] = edgecapture;
         default: readdata = '0;
      endcase
   end

endmodule
